// File: rtl/dialer_emulator.sv
// Rotary-dial line emulator: replays a latched 7-digit factorial expansion as
// rest-contact breaks and break pulses, least-significant digit first.
module dialer_emulator #(
  parameter int LEAD_CYC  = 2500000,
  parameter int HIGH_CYC  = 3000000,
  parameter int LOW_CYC   = 2000000,
  parameter int TRAIL_CYC = 2500000,
  parameter int GAP_CYC   = 25000000,
  parameter int CW        = 26
) (
  input  logic       CLK,
  input  logic       restart,
  input  logic       start,
  input  logic       of1,
  input  logic [1:0] of2,
  input  logic [1:0] of3,
  input  logic [2:0] of4,
  input  logic [2:0] of5,
  input  logic [2:0] of6,
  input  logic [2:0] of7,
  output logic       dialer_in_rest,
  output logic       dialer_pulses,
  output logic       busy,
  output logic       done,
  output logic [2:0] digit_index,
  output logic       clamped
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_HIGH, S_LOW, S_TRAIL, S_GAP
  } state_t;

  localparam logic [CW-1:0] LEAD_LD  = CW'(LEAD_CYC - 1);
  localparam logic [CW-1:0] HIGH_LD  = CW'(HIGH_CYC - 1);
  localparam logic [CW-1:0] LOW_LD   = CW'(LOW_CYC - 1);
  localparam logic [CW-1:0] TRAIL_LD = CW'(TRAIL_CYC - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYC - 1);

  function automatic logic [2:0] sat_digit(input logic [2:0] v, input logic [2:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    n_q, n_d;
  logic [2:0]    idx_q, idx_d;
  logic          rest_q, rest_d;
  logic          pulses_q, pulses_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          clamped_q, clamped_d;
  logic [2:0]    dig_q [7];
  logic [2:0]    dig_in [7];
  logic [2:0]    dig_sat [7];
  logic          any_clamp;
  logic          accept;

  assign accept = !restart && start && (state_q == S_IDLE);

  always_comb begin
    dig_in[0] = {2'b00, of1};
    dig_in[1] = {1'b0, of2};
    dig_in[2] = {1'b0, of3};
    dig_in[3] = of4;
    dig_in[4] = of5;
    dig_in[5] = of6;
    dig_in[6] = of7;
    any_clamp = 1'b0;
    for (int i = 0; i < 7; i++) begin
      // Digit i may take at most i+1 pulses.
      dig_sat[i] = sat_digit(dig_in[i], 3'(i + 1));
      if (dig_in[i] > 3'(i + 1)) any_clamp = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    n_d       = n_q;
    idx_d     = idx_q;
    clamped_d = clamped_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LEAD;
          cnt_d     = LEAD_LD;
          idx_d     = 3'd0;
          n_d       = dig_sat[0];
          clamped_d = any_clamp;
        end
      end
      S_LEAD, S_LOW: begin
        if (cnt_q == '0) begin
          if (n_q != 3'd0) begin
            state_d = S_HIGH;
            cnt_d   = HIGH_LD;
          end else begin
            state_d = S_TRAIL;
            cnt_d   = TRAIL_LD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HIGH: begin
        if (cnt_q == '0) begin
          state_d = S_LOW;
          cnt_d   = LOW_LD;
          n_d     = n_q - 3'd1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_TRAIL: begin
        if (cnt_q == '0) begin
          if (idx_q == 3'd6) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_GAP;
            cnt_d   = GAP_LD;
            idx_d   = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_LEAD;
          cnt_d   = LEAD_LD;
          n_d     = dig_q[idx_q];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Line outputs are decoded from the next state so they leave the registers glitch-free.
    rest_d   = (state_d == S_IDLE) || (state_d == S_GAP);
    pulses_d = (state_d == S_HIGH);
    busy_d   = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (restart) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      n_q       <= 3'd0;
      idx_q     <= 3'd0;
      rest_q    <= 1'b1;
      pulses_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      clamped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      rest_q    <= rest_d;
      pulses_q  <= pulses_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      clamped_q <= clamped_d;
    end
  end

  // Latched digit values are pure data and need no reset.
  always_ff @(posedge CLK) begin
    if (accept) dig_q <= dig_sat;
  end

  assign dialer_in_rest = rest_q;
  assign dialer_pulses  = pulses_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign digit_index    = idx_q;
  assign clamped        = clamped_q;

endmodule
